// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - parametrised serial bit-pattern detector
// Moore/Mealy output, overlap or non-overlap matching, sample enable, saturating match counter.
module seq_pattern_detector #(
  parameter int                 PAT_W   = 2,
  parameter logic [PAT_W-1:0]   PATTERN = 2'b01,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MOORE   = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             en,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int              VC_W   = $clog2(PAT_W + 1);
  localparam logic [VC_W-1:0] VC_MAX = VC_W'(PAT_W);
  localparam logic [VC_W-1:0] VC_ARM = VC_W'(PAT_W - 1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] win;
  logic [VC_W-1:0]  vcnt;
  logic [VC_W-1:0]  vcnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sample;
  logic             hit;

  assign sample = en && !clear;
  assign win    = {hist[PAT_W-2:0], a};
  // vcnt keeps bits from before reset/clear (or consumed by a non-overlap match) out of the window
  assign hit    = sample && (win == PATTERN) && (vcnt >= VC_ARM);

  always_comb begin
    vcnt_nxt = vcnt;
    if (hit && !OVERLAP) begin
      vcnt_nxt = '0;
    end else if (vcnt != VC_MAX) begin
      vcnt_nxt = vcnt + 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = match_count;
    if (hit && !(&match_count)) begin
      cnt_nxt = match_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      vcnt        <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clear) begin
      hist        <= '0;
      vcnt        <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (en) begin
      hist        <= win;
      vcnt        <= vcnt_nxt;
      match_count <= cnt_nxt;
      count_sat   <= &cnt_nxt;
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic y_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          y_q <= 1'b0;
        end else begin
          y_q <= hit;
        end
      end
      assign y = y_q;
    end else begin : g_mealy
      assign y = hit;
    end
  endgenerate

endmodule
